taller_ram_fill_verify: RTL and testbench
=========================================

Name: taller_ram_fill_verify

Overview:
- Avalon-MM master engine placed directly upstream of the 4096x32 single-port on-chip RAM. It drives the RAM's address, byteenable, chipselect, write, writedata and clken inputs, and consumes its readdata.
- Firmware configures it through a small Avalon-MM CSR slave.
- It bulk-fills a RAM window with a constant or incrementing pattern, or reads the window back and verifies it. Used for boot-time clearing of alarm/time tables and for memory self-test.

Parameters:
- ADDR_W, 12, RAM word-address width; the RAM depth is 2^ADDR_W.
- DATA_W, 32, RAM data width; byteenable width is DATA_W/8.
- CNT_W, 13, width of the word-count and error-count registers; must hold 2^ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- csr_address  in  3  CSR word address
- csr_write  in  1  CSR write strobe
- csr_read  in  1  CSR read strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, valid 1 cycle after csr_read
- irq  out  1  done interrupt, level
- m_address  out  ADDR_W  RAM word address
- m_byteenable  out  DATA_W/8  RAM byte enables
- m_chipselect  out  1  RAM chipselect
- m_write  out  1  RAM write
- m_writedata  out  DATA_W  RAM write data
- m_clken  out  1  RAM clock enable
- m_readdata  in  DATA_W  RAM read data, valid 1 cycle after a read address is presented

Behaviour:
- Clocking and reset:
  - Single clock domain `clk`. Reset `reset` is synchronous and active-high.
  - All outputs are registered.
  - After a reset edge, every output is 0 and the FSM is in IDLE. All CSRs reset to 0.
- CSR map (word offsets):
  - 0 CTRL (W): bit0 start, bit1 mode (0 = fill, 1 = verify), bit2 abort, bit3 incr (pattern +1 per word), bit4 irq_en. Bit4 is stored and readable; bits 0 and 2 are pulses.
  - 1 START_ADDR [ADDR_W-1:0]
  - 2 COUNT [CNT_W-1:0]
  - 3 PATTERN [31:0]
  - 4 STATUS (R): bit0 busy, bit1 done, bit2 err. A write with bit1 = 1 clears done; a write with bit2 = 1 clears err.
  - 5 ERR_COUNT (R)
  - 6 FIRST_ERR_ADDR (R)
  - 7 reads 0.
- CSR access rules:
  - Writes to offsets 1–3 while busy are ignored.
  - A start pulse while busy is ignored.
  - Reads of write-only bits return 0.
- FSM states: IDLE, FILL, VERIFY, DRAIN.
- IDLE:
  - On start, load addr = START_ADDR, remaining = COUNT, exp = PATTERN.
  - Clear ERR_COUNT, FIRST_ERR_ADDR and err; set busy.
  - If COUNT = 0, go straight to done: busy drops next cycle, no RAM access occurs.
  - Otherwise go to FILL or VERIFY according to mode.
- FILL:
  - Every cycle: m_chipselect = 1, m_write = 1, m_clken = 1, m_byteenable = all ones, m_address = addr, m_writedata = exp.
  - Then addr += 1 modulo 2^ADDR_W (4095 wraps to 0), remaining -= 1, exp += incr.
  - When the last word is issued, the next state is IDLE with done = 1.
  - Throughput is 1 word per cycle, so COUNT words take exactly COUNT cycles.
- VERIFY:
  - Every cycle: m_chipselect = 1, m_write = 0, m_clken = 1, m_address = addr.
  - Expected value and address are pipelined one stage.
  - In the following cycle, m_readdata is compared with the delayed expected value.
  - On mismatch: err = 1 and ERR_COUNT += 1, saturating at all ones. FIRST_ERR_ADDR captures the address only on the first mismatch.
  - After the last read is issued, go to DRAIN: 1 cycle, master idle, final compare performed. Then IDLE with done = 1.
- Master idle value: whenever not in FILL or VERIFY, m_chipselect = m_write = m_clken = 0. Address and data hold their last values.
- Abort:
  - An abort pulse in any busy state forces IDLE on the next edge with done = 1.
  - No further RAM accesses are issued and any compare in flight is discarded.
  - Abort while in IDLE has no effect.
- Reset mid-operation: the operation is terminated, all state is cleared, and done is not set.
- irq = done & irq_en, registered.
- busy = (state != IDLE).
- A new start with done still set is accepted; done stays set until firmware clears it.

Test Plan:
- Fill, incrementing pattern: START_ADDR = 0x010, COUNT = 4, PATTERN = 0xA0000000, incr = 1 → writes at 0x010..0x013 with data 0xA0000000..0xA0000003 on 4 consecutive cycles; done = 1 and busy = 0 on the 5th cycle.
- Address wrap-around: START_ADDR = 0xFFE, COUNT = 4, constant PATTERN = 0x5A5A5A5A → write addresses 0xFFE, 0xFFF, 0x000, 0x001; all m_byteenable = 0xF.
- Verify with one corrupted word: fill 0x100..0x107 with 0x12345678, then drive m_readdata = 0xDEADBEEF for address 0x103 → ERR_COUNT = 1, FIRST_ERR_ADDR = 0x103, err = 1; done is asserted 1 cycle after the last read issue (DRAIN).
- Abort mid-fill: COUNT = 100, abort written on the 10th write cycle → no m_write after the abort edge; done = 1; irq = 1 with irq_en = 1; clearing done drops irq.
- Zero count and busy-guard: COUNT = 0 start → done with no chipselect. During a COUNT = 50 run, a write of START_ADDR = 0x222 and a second start are both ignored.
- Reset mid-verify: assert reset for 1 cycle during a VERIFY run → all master outputs 0 next cycle; STATUS = 0, ERR_COUNT = 0, irq = 0.

Source files
------------

// File: rtl/taller_ram_fill_verify.sv
// Avalon-MM fill/verify engine sitting in front of the 4096x32 single-port on-chip RAM.
// Firmware programs a window over the CSR slave; the engine streams one RAM word per cycle.
module taller_ram_fill_verify #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            csr_address,
  input  logic                  csr_write,
  input  logic                  csr_read,
  input  logic [31:0]           csr_writedata,
  output logic [31:0]           csr_readdata,
  output logic                  irq,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN} state_t;

  state_t                r_state, w_next;
  logic [ADDR_W-1:0]     r_startAddr, r_addr, r_pAddr, r_firstErr, w_issAddr;
  logic [CNT_W-1:0]      r_count, r_rem, r_errCnt, w_issRem;
  logic [31:0]           r_pattern, r_rdata, w_rdMux;
  logic [DATA_W-1:0]     r_exp, r_curExp, r_pExp, w_issExp;
  logic                  r_runIncr, r_irqEn, r_done, r_err, r_irq, r_pv, w_issIncr;
  logic                  w_ctrlWr, w_statWr, w_start, w_abort, w_busy;
  logic                  w_issue, w_doneSet, w_mismatch;
  logic [ADDR_W-1:0]     r_mAddr;
  logic [DATA_W/8-1:0]   r_mBe;
  logic                  r_mCs, r_mWrite, r_mClken;
  logic [DATA_W-1:0]     r_mWdata;

  assign w_busy     = (r_state != S_IDLE);
  assign w_ctrlWr   = csr_write && (csr_address == 3'd0);
  assign w_statWr   = csr_write && (csr_address == 3'd4);
  assign w_start    = w_ctrlWr && csr_writedata[0] && !w_busy;
  assign w_abort    = w_ctrlWr && csr_writedata[2] && w_busy;
  assign w_doneSet  = w_busy && (w_next == S_IDLE);
  assign w_mismatch = r_pv && !w_abort && (m_readdata != r_pExp);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the word to issue on the coming edge; the first word comes straight from the CSRs.
  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_issAddr = r_addr;
    w_issExp  = r_exp;
    w_issRem  = r_rem - 1'b1;
    w_issIncr = r_runIncr;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_issAddr = r_startAddr;
          w_issExp  = DATA_W'(r_pattern);
          w_issRem  = r_count - 1'b1;
          w_issIncr = csr_writedata[3];
          if (r_count == '0) begin
            w_next = S_DRAIN;
          end else begin
            w_issue = 1'b1;
            w_next  = csr_writedata[1] ? S_VERIFY : S_FILL;
          end
        end
      end
      S_FILL: begin
        if (w_abort || r_rem == '0) w_next = S_IDLE;
        else                        w_issue = 1'b1;
      end
      S_VERIFY: begin
        if (w_abort)            w_next = S_IDLE;
        else if (r_rem == '0)   w_next = S_DRAIN;
        else                    w_issue = 1'b1;
      end
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdMux = '0;
    case (csr_address)
      3'd0: w_rdMux = {27'd0, r_irqEn, 4'd0};
      3'd1: w_rdMux = 32'(r_startAddr);
      3'd2: w_rdMux = 32'(r_count);
      3'd3: w_rdMux = r_pattern;
      3'd4: w_rdMux = {29'd0, r_err, r_done, w_busy};
      3'd5: w_rdMux = 32'(r_errCnt);
      3'd6: w_rdMux = 32'(r_firstErr);
      default: w_rdMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_startAddr <= '0;
      r_count     <= '0;
      r_pattern   <= '0;
      r_irqEn     <= 1'b0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_exp       <= '0;
      r_curExp    <= '0;
      r_runIncr   <= 1'b0;
      r_mAddr     <= '0;
      r_mBe       <= '0;
      r_mCs       <= 1'b0;
      r_mWrite    <= 1'b0;
      r_mWdata    <= '0;
      r_mClken    <= 1'b0;
      r_pv        <= 1'b0;
      r_pExp      <= '0;
      r_pAddr     <= '0;
      r_errCnt    <= '0;
      r_firstErr  <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_irq       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_ctrlWr) r_irqEn <= csr_writedata[4];
      if (csr_write && !w_busy) begin
        case (csr_address)
          3'd1: r_startAddr <= csr_writedata[ADDR_W-1:0];
          3'd2: r_count     <= csr_writedata[CNT_W-1:0];
          3'd3: r_pattern   <= csr_writedata;
          default: ;
        endcase
      end

      if (w_issue) begin
        r_mCs     <= 1'b1;
        r_mClken  <= 1'b1;
        r_mWrite  <= (w_next == S_FILL);
        r_mBe     <= '1;
        r_mAddr   <= w_issAddr;
        if (w_next == S_FILL) r_mWdata <= w_issExp;
        r_curExp  <= w_issExp;
        r_addr    <= w_issAddr + 1'b1;
        r_exp     <= w_issExp + DATA_W'(w_issIncr);
        r_rem     <= w_issRem;
      end else begin
        r_mCs    <= 1'b0;
        r_mWrite <= 1'b0;
        r_mClken <= 1'b0;
      end
      if (w_start) r_runIncr <= csr_writedata[3];

      // Read data lags the address by one cycle, so expected value and address ride one stage behind.
      r_pv    <= (r_state == S_VERIFY) && !w_abort;
      r_pExp  <= r_curExp;
      r_pAddr <= r_mAddr;

      if (w_start) begin
        r_errCnt   <= '0;
        r_firstErr <= '0;
        r_err      <= 1'b0;
      end else if (w_mismatch) begin
        r_err <= 1'b1;
        if (r_errCnt != '1) r_errCnt <= r_errCnt + 1'b1;
        if (r_errCnt == '0) r_firstErr <= r_pAddr;
      end else if (w_statWr && csr_writedata[2]) begin
        r_err <= 1'b0;
      end

      if (w_doneSet)                          r_done <= 1'b1;
      else if (w_statWr && csr_writedata[1])  r_done <= 1'b0;

      r_irq   <= r_done & r_irqEn;
      r_rdata <= csr_read ? w_rdMux : 32'd0;
    end
  end

  assign csr_readdata = r_rdata;
  assign irq          = r_irq;
  assign m_address    = r_mAddr;
  assign m_byteenable = r_mBe;
  assign m_chipselect = r_mCs;
  assign m_write      = r_mWrite;
  assign m_writedata  = r_mWdata;
  assign m_clken      = r_mClken;

endmodule

// File: tb/tb_taller_ram_fill_verify.sv
// Randomised self-checking bench for taller_ram_fill_verify with a behavioural RAM and scoreboard.
module tb_taller_ram_fill_verify;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_address;
  logic        csr_write, csr_read;
  logic [31:0] csr_writedata, csr_readdata;
  logic        irq;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write, m_clken;
  logic [31:0] m_writedata, m_readdata;

  int testsRun = 0;
  int testsFailed = 0;
  int wrCount = 0;
  int csCount = 0;
  logic [31:0] ram [0:DEPTH-1];
  logic        corruptEn = 1'b0;
  logic [11:0] corruptAddr = '0;

  taller_ram_fill_verify dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .irq(irq),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle of read latency and an optional corrupted word.
  always @(posedge clk) begin
    if (m_chipselect && m_clken) begin
      csCount <= csCount + 1;
      if (m_write) begin
        ram[m_address] <= m_writedata;
        wrCount <= wrCount + 1;
      end else begin
        m_readdata <= (corruptEn && m_address == corruptAddr) ? 32'hDEADBEEF : ram[m_address];
      end
    end
  end

  task automatic csrWrite(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csrRead(input logic [2:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic setup(input logic [11:0] s, input int n, input logic [31:0] p);
    csrWrite(3'd1, 32'(s));
    csrWrite(3'd2, 32'(n));
    csrWrite(3'd3, p);
    csrWrite(3'd4, 32'h6);
  endtask

  task automatic waitIdle(input int budget, input string name);
    logic [31:0] st;
    int n = 0;
    do begin
      csrRead(3'd4, st);
      n++;
    end while (st[0] && n < budget);
    testsRun++;
    if (st[0]) begin
      testsFailed++;
      $display("[TB] FAIL %s timeout: still busy after %0d polls", name, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({m_chipselect, m_write, m_clken, m_address, m_writedata, m_byteenable, irq, csr_readdata} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got cs=%b wr=%b ck=%b a=%h d=%h be=%h irq=%b rd=%h expected all 0",
               m_chipselect, m_write, m_clken, m_address, m_writedata, m_byteenable, irq, csr_readdata);
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      csrRead(3'(a), v);
      testsRun++;
      if (v !== 32'd0) begin
        testsFailed++;
        $display("[TB] FAIL reset_csr%0d got %h expected 0", a, v);
      end
    end
  endtask

  task automatic test_fill_incr();
    logic [31:0] v;
    int w0;
    setup(12'h010, 4, 32'hA0000000);
    w0 = wrCount;
    csrWrite(3'd0, 32'h09);
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if ({m_chipselect, m_write, m_clken, m_address, m_writedata} !== {3'b111, 12'(12'h010 + i), 32'hA0000000 + 32'(i)}) begin
        testsFailed++;
        $display("[TB] FAIL fill_incr_word%0d got cs=%b wr=%b ck=%b a=%h d=%h expected 111 a=%h d=%h",
                 i, m_chipselect, m_write, m_clken, m_address, m_writedata, 12'h010 + i, 32'hA0000000 + 32'(i));
      end
      @(negedge clk);
    end
    csrRead(3'd4, v);
    testsRun++;
    if (m_write !== 1'b0 || v[2:0] !== 3'b010) begin
      testsFailed++;
      $display("[TB] FAIL fill_incr_done got wr=%b status=%b expected wr=0 status=010", m_write, v[2:0]);
    end
    testsRun++;
    if (wrCount - w0 != 4 || ram[12'h012] !== 32'hA0000002) begin
      testsFailed++;
      $display("[TB] FAIL fill_incr_count got %0d writes ram[012]=%h expected 4 and a0000002", wrCount - w0, ram[12'h012]);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] ea;
    setup(12'hFFE, 4, 32'h5A5A5A5A);
    csrWrite(3'd0, 32'h01);
    for (int i = 0; i < 4; i++) begin
      ea = 12'hFFE + 12'(i);
      testsRun++;
      if ({m_write, m_address, m_byteenable, m_writedata} !== {1'b1, ea, 4'hF, 32'h5A5A5A5A}) begin
        testsFailed++;
        $display("[TB] FAIL wrap_word%0d got wr=%b a=%h be=%h d=%h expected wr=1 a=%h be=f d=5a5a5a5a",
                 i, m_write, m_address, m_byteenable, m_writedata, ea);
      end
      @(negedge clk);
    end
    waitIdle(20, "wrap");
  endtask

  task automatic test_verify_corrupt();
    logic [31:0] v;
    setup(12'h100, 8, 32'h12345678);
    csrWrite(3'd0, 32'h01);
    waitIdle(30, "verify_fill");
    csrWrite(3'd4, 32'h6);
    corruptAddr = 12'h103;
    corruptEn = 1'b1;
    csrWrite(3'd0, 32'h03);
    for (int i = 0; i < 8; i++) begin
      testsRun++;
      if ({m_chipselect, m_write, m_clken, m_address} !== {3'b101, 12'(12'h100 + i)}) begin
        testsFailed++;
        $display("[TB] FAIL verify_read%0d got cs=%b wr=%b ck=%b a=%h expected 101 a=%h",
                 i, m_chipselect, m_write, m_clken, m_address, 12'h100 + i);
      end
      @(negedge clk);
    end
    testsRun++;
    if (m_chipselect !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL verify_drain_cs got %b expected 0", m_chipselect);
    end
    csrRead(3'd4, v);
    testsRun++;
    if (v[2:0] !== 3'b101) begin
      testsFailed++;
      $display("[TB] FAIL verify_drain_status got %b expected 101", v[2:0]);
    end
    csrRead(3'd4, v);
    testsRun++;
    if (v[2:0] !== 3'b110) begin
      testsFailed++;
      $display("[TB] FAIL verify_done_status got %b expected 110", v[2:0]);
    end
    csrRead(3'd5, v);
    testsRun++;
    if (v !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL verify_errcount got %0d expected 1", v);
    end
    csrRead(3'd6, v);
    testsRun++;
    if (v !== 32'h103) begin
      testsFailed++;
      $display("[TB] FAIL verify_first_err got %h expected 103", v);
    end
    corruptEn = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] v;
    int w0;
    setup(12'h400, 100, 32'hC0DE0000);
    w0 = wrCount;
    csrWrite(3'd0, 32'h11);
    repeat (9) @(negedge clk);
    csrWrite(3'd0, 32'h14);
    testsRun++;
    if (m_write !== 1'b0 || m_chipselect !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_idle got wr=%b cs=%b expected 0 0", m_write, m_chipselect);
    end
    csrRead(3'd4, v);
    testsRun++;
    if (v[2:0] !== 3'b010 || wrCount - w0 != 10) begin
      testsFailed++;
      $display("[TB] FAIL abort_status got status=%b writes=%0d expected 010 and 10", v[2:0], wrCount - w0);
    end
    testsRun++;
    if (irq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL abort_irq got %b expected 1", irq);
    end
    csrRead(3'd0, v);
    testsRun++;
    if (v !== 32'h10) begin
      testsFailed++;
      $display("[TB] FAIL ctrl_readback got %h expected 10", v);
    end
    csrWrite(3'd4, 32'h2);
    @(negedge clk);
    testsRun++;
    if (irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_irq_clear got %b expected 0", irq);
    end
  endtask

  task automatic test_zero_busy_guard();
    logic [31:0] v;
    int c0, w0, bad;
    setup(12'h500, 0, 32'h11111111);
    c0 = csCount;
    csrWrite(3'd0, 32'h01);
    csrRead(3'd4, v);
    testsRun++;
    if (v[2:0] !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL zero_busy got %b expected 001", v[2:0]);
    end
    csrRead(3'd4, v);
    testsRun++;
    if (v[2:0] !== 3'b010 || csCount != c0) begin
      testsFailed++;
      $display("[TB] FAIL zero_done got status=%b cs_cycles=%0d expected 010 and 0", v[2:0], csCount - c0);
    end
    setup(12'h300, 50, 32'h77770000);
    w0 = wrCount;
    csrWrite(3'd0, 32'h09);
    repeat (3) @(negedge clk);
    csrWrite(3'd1, 32'h222);
    csrWrite(3'd0, 32'h01);
    waitIdle(200, "busy_guard");
    csrRead(3'd1, v);
    testsRun++;
    if (v !== 32'h300 || wrCount - w0 != 50) begin
      testsFailed++;
      $display("[TB] FAIL busy_guard got start=%h writes=%0d expected 300 and 50", v, wrCount - w0);
    end
    bad = 0;
    for (int i = 0; i < 50; i++)
      if (ram[12'h300 + 12'(i)] !== 32'h77770000 + 32'(i)) bad++;
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL busy_guard_data got %0d bad words expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_verify();
    logic [31:0] v;
    setup(12'h600, 20, 32'hABCD0000);
    csrWrite(3'd0, 32'h09);
    waitIdle(60, "rst_fill");
    csrWrite(3'd4, 32'h6);
    corruptAddr = 12'h600;
    corruptEn = 1'b1;
    csrWrite(3'd0, 32'h1B);
    repeat (4) @(negedge clk);
    csrRead(3'd5, v);
    testsRun++;
    if (v !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL rst_pre_errcount got %0d expected 1", v);
    end
    reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({m_chipselect, m_write, m_clken, m_address, m_writedata, m_byteenable, irq} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_outputs got cs=%b wr=%b ck=%b a=%h d=%h be=%h irq=%b expected all 0",
               m_chipselect, m_write, m_clken, m_address, m_writedata, m_byteenable, irq);
    end
    reset = 1'b0;
    corruptEn = 1'b0;
    csrRead(3'd4, v);
    testsRun++;
    if (v !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_status got %h expected 0", v);
    end
    csrRead(3'd5, v);
    testsRun++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_errcount got %0d irq=%b expected 0 0", v, irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] v, p, e;
    logic [11:0] s;
    int n, inc, bad, w0, c, off;
    for (int it = 0; it < 6; it++) begin
      s = 12'($urandom_range(0, DEPTH - 1));
      n = $urandom_range(1, 40);
      p = $urandom;
      inc = $urandom_range(0, 1);
      setup(s, n, p);
      w0 = wrCount;
      csrWrite(3'd0, 32'h01 | (32'(inc) << 3));
      waitIdle(100, "rand_fill");
      bad = 0;
      for (int i = 0; i < n; i++) begin
        e = p + 32'(i) * 32'(inc);
        if (ram[12'(s + 12'(i))] !== e) bad++;
      end
      testsRun++;
      if (bad != 0 || wrCount - w0 != n) begin
        testsFailed++;
        $display("[TB] FAIL rand_fill%0d got %0d bad words %0d writes expected 0 and %0d", it, bad, wrCount - w0, n);
      end
      c = $urandom_range(0, 1);
      off = $urandom_range(0, n - 1);
      corruptAddr = s + 12'(off);
      corruptEn = (c == 1);
      csrWrite(3'd4, 32'h6);
      csrWrite(3'd0, 32'h03 | (32'(inc) << 3));
      waitIdle(100, "rand_verify");
      csrRead(3'd5, v);
      testsRun++;
      if (v !== 32'(c)) begin
        testsFailed++;
        $display("[TB] FAIL rand_verify%0d_errcount got %0d expected %0d", it, v, c);
      end
      csrRead(3'd6, v);
      testsRun++;
      if (v !== (c == 1 ? 32'(corruptAddr) : 32'd0)) begin
        testsFailed++;
        $display("[TB] FAIL rand_verify%0d_first got %h expected %h", it, v, (c == 1 ? 32'(corruptAddr) : 32'd0));
      end
      corruptEn = 1'b0;
      csrWrite(3'd3, p + 32'd1);
      csrWrite(3'd0, 32'h03 | (32'(inc) << 3));
      waitIdle(100, "rand_allbad");
      csrRead(3'd5, v);
      testsRun++;
      if (v !== 32'(n)) begin
        testsFailed++;
        $display("[TB] FAIL rand_allbad%0d_errcount got %0d expected %0d", it, v, n);
      end
      csrRead(3'd6, v);
      testsRun++;
      if (v !== 32'(s)) begin
        testsFailed++;
        $display("[TB] FAIL rand_allbad%0d_first got %h expected %h", it, v, s);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    csr_address = '0;
    csr_write = 1'b0;
    csr_read = 1'b0;
    csr_writedata = '0;
    @(negedge clk);
    test_reset();
    test_fill_incr();
    test_wrap();
    test_verify_corrupt();
    test_abort();
    test_zero_busy_guard();
    test_reset_mid_verify();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
